mem_responder: RTL and testbench

- Memory-side responder for the multicycle MIPS core's shared instruction/data memory port.
- Accepts one request at a time: address, write enable, write data.
- Inserts a programmable number of wait states, then returns read data with a one-cycle ready pulse, or commits the write.
- Flags misaligned and out-of-range accesses instead of servicing them; gives the core a realistic latency-bearing memory to stall against.

---
 rtl/mem_pkg.sv | 14 +
 rtl/mem_responder_if.sv | 23 ++
 rtl/mem_array.sv | 27 ++
 rtl/mem_responder.sv | 145 ++++++++++++++
 tb/tb_mem_responder.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the mem_responder memory model.
package mem_pkg;

    // Responder states: idle, wait-state countdown, one-cycle response
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int WORD_BYTES = 4;
    localparam int WAIT_W     = 4;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the multicycle core (master) and the memory responder (slave).
interface mem_responder_if;

    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        ready;
    logic        fault;
    logic        busy;

    modport master (
        output req, we, addr, wd,
        input  rd, ready, fault, busy
    );

    modport slave (
        input  req, we, addr, wd,
        output rd, ready, fault, busy
    );

endinterface

// File: rtl/mem_array.sv
// Synchronous single-port WORDS x 32 storage with write enable and registered read.
module mem_array #(
    parameter int WORDS = 256,
    localparam int IDX_W = $clog2(WORDS)
) (
    input  logic             clk,
    input  logic             en,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wd,
    output logic [31:0]      rd
);

    logic [31:0] mem [WORDS];

    // One access per enabled edge: commit the write, or register the read word
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[idx] <= wd;
            end else begin
                rd <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Latency-bearing memory responder for the multicycle MIPS core.
// Optional MEM_RESPONDER_STATS_EN adds read/write/fault counters as extra outputs.
module mem_responder
    import mem_pkg::*;
#(
    parameter int WORDS       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    mem_responder_if.slave  bus
`ifdef MEM_RESPONDER_STATS_EN
    ,
    output logic [31:0]     rd_count,
    output logic [31:0]     wr_count,
    output logic [15:0]     fault_count
`endif
);

    localparam int                IDX_W     = $clog2(WORDS);
    localparam logic [31:0]       LIMIT     = 32'(WORD_BYTES * WORDS);
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_CYCLES);

    state_t            state;
    state_t            state_next;
    logic [WAIT_W-1:0] count;
    logic              we_q;
    logic              fault_q;
    logic [31:0]       addr_q;
    logic [31:0]       wd_q;

    logic              accept;
    logic              acc_we;
    logic [31:0]       acc_addr;
    logic [31:0]       acc_wd;
    logic              acc_fault;
    logic              enter_resp;
    logic              arr_en;
    logic [31:0]       arr_rd;

    // With zero wait states the array is accessed on the accepting edge itself,
    // so the access fields bypass the latches while a request is being accepted.
    assign accept     = (state == IDLE) && bus.req;
    assign acc_we     = accept ? bus.we   : we_q;
    assign acc_addr   = accept ? bus.addr : addr_q;
    assign acc_wd     = accept ? bus.wd   : wd_q;
    assign acc_fault  = (acc_addr[1:0] != 2'b00) || (acc_addr >= LIMIT);
    assign enter_resp = (state_next == RESP) && (state != RESP);
    assign arr_en     = enter_resp && reset_n && !acc_fault;

    mem_array #(.WORDS(WORDS)) u_array (
        .clk (clk),
        .en  (arr_en),
        .we  (acc_we),
        .idx (acc_addr[IDX_W+1:2]),
        .wd  (acc_wd),
        .rd  (arr_rd)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request latches and wait-state counter
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count   <= '0;
            we_q    <= 1'b0;
            fault_q <= 1'b0;
            addr_q  <= '0;
            wd_q    <= '0;
        end else if (accept) begin
            count   <= WAIT_INIT;
            we_q    <= bus.we;
            fault_q <= acc_fault;
            addr_q  <= bus.addr;
            wd_q    <= bus.wd;
        end else if (state == WAIT) begin
            count   <= count - 4'd1;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.req) begin
                    state_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (count == 4'd1) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Bus outputs: data only for a good read, and only during the response cycle
    always_comb begin
        bus.ready = 1'b0;
        bus.fault = 1'b0;
        bus.rd    = '0;
        bus.busy  = (state != IDLE);
        if (state == RESP) begin
            bus.ready = 1'b1;
            bus.fault = fault_q;
            if (!fault_q && !we_q) begin
                bus.rd = arr_rd;
            end
        end
    end

`ifdef MEM_RESPONDER_STATS_EN
    // Access statistics, counted once per response cycle
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_count    <= '0;
            wr_count    <= '0;
            fault_count <= '0;
        end else if (state == RESP) begin
            if (fault_q) begin
                fault_count <= fault_count + 16'd1;
            end else if (we_q) begin
                wr_count <= wr_count + 32'd1;
            end else begin
                rd_count <= rd_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: one instance with two wait states, one with none.
module tb_mem_responder;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    mem_responder_if bus2 ();
    mem_responder_if bus0 ();

`ifdef MEM_RESPONDER_STATS_EN
    logic [31:0] rd_count2, wr_count2, rd_count0, wr_count0;
    logic [15:0] fault_count2, fault_count0;
`endif

    mem_responder #(.WORDS(256), .WAIT_CYCLES(2)) dut2 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus2)
`ifdef MEM_RESPONDER_STATS_EN
        ,
        .rd_count    (rd_count2),
        .wr_count    (wr_count2),
        .fault_count (fault_count2)
`endif
    );

    mem_responder #(.WORDS(256), .WAIT_CYCLES(0)) dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus0)
`ifdef MEM_RESPONDER_STATS_EN
        ,
        .rd_count    (rd_count0),
        .wr_count    (wr_count0),
        .fault_count (fault_count0)
`endif
    );

    int compared = 0;
    int mismatched = 0;

    // Reference memory per instance: contents plus which words hold known data
    logic [31:0] model_mem [2][256];
    bit          model_valid [2][256];

    function automatic int waitOf(input int sel);
        return (sel == 0) ? 2 : 0;
    endfunction

    function automatic logic [31:0] obsRd(input int sel);
        return (sel == 0) ? bus2.rd : bus0.rd;
    endfunction

    function automatic logic obsReady(input int sel);
        return (sel == 0) ? bus2.ready : bus0.ready;
    endfunction

    function automatic logic obsFault(input int sel);
        return (sel == 0) ? bus2.fault : bus0.fault;
    endfunction

    function automatic logic obsBusy(input int sel);
        return (sel == 0) ? bus2.busy : bus0.busy;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic driveReq(input int sel, input logic req, input logic we,
                            input logic [31:0] addr, input logic [31:0] wd);
        if (sel == 0) begin
            bus2.req = req; bus2.we = we; bus2.addr = addr; bus2.wd = wd;
        end else begin
            bus0.req = req; bus0.we = we; bus0.addr = addr; bus0.wd = wd;
        end
    endtask

    // Issue one request and wait (bounded) for its ready pulse
    task automatic applyStimulus(input int sel, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wd, output int lat,
                                 output logic [31:0] rd_o, output logic fault_o, output logic ready_o);
        @(negedge clk);
        driveReq(sel, 1'b1, we, addr, wd);
        @(posedge clk);
        lat = 0;
        ready_o = 1'b0;
        while (lat < 40 && !ready_o) begin
            @(negedge clk);
            if (lat == 0) driveReq(sel, 1'b0, 1'b0, '0, '0);
            lat++;
            ready_o = obsReady(sel);
        end
        rd_o = obsRd(sel);
        fault_o = obsFault(sel);
    endtask

    // Full transaction checked against the reference model
    task automatic doTransaction(input int sel, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wd, input string tag);
        int          lat;
        logic [31:0] rd_o;
        logic        fault_o, ready_o;
        logic        exp_fault;
        logic [31:0] exp_rd;
        int          idx;
        idx = int'(addr[9:2]);
        exp_fault = (addr % 4 != 0) || (addr >= 32'd1024);
        exp_rd = (exp_fault || we) ? 32'h0 : model_mem[sel][idx];
        applyStimulus(sel, we, addr, wd, lat, rd_o, fault_o, ready_o);
        checkOutput({tag, "_ready"}, 32'(ready_o), 32'd1);
        checkOutput({tag, "_latency"}, 32'(lat), 32'(waitOf(sel) + 1));
        checkOutput({tag, "_fault"}, 32'(fault_o), 32'(exp_fault));
        checkOutput({tag, "_rd"}, rd_o, exp_rd);
        if (we && !exp_fault) begin
            model_mem[sel][idx] = wd;
            model_valid[sel][idx] = 1'b1;
        end
        @(negedge clk);
        checkOutput({tag, "_ready_drop"}, 32'(obsReady(sel)), 32'd0);
        checkOutput({tag, "_rd_drop"}, obsRd(sel), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          n_ready;
        int          pulse_at;
        logic [31:0] pulse_rd;
        int          sel;
        int          kind;
        int          idx;
        logic [31:0] addr;
        logic        we;

        driveReq(0, 1'b0, 1'b0, '0, '0);
        driveReq(1, 1'b0, 1'b0, '0, '0);

        // Reset held for two edges, then idle quietly
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            checkOutput($sformatf("reset_rd%0d", s), obsRd(s), 32'd0);
            checkOutput($sformatf("reset_ready%0d", s), 32'(obsReady(s)), 32'd0);
            checkOutput($sformatf("reset_fault%0d", s), 32'(obsFault(s)), 32'd0);
            checkOutput($sformatf("reset_busy%0d", s), 32'(obsBusy(s)), 32'd0);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput($sformatf("idle_ready_%0d", i), 32'({bus2.ready, bus0.ready}), 32'd0);
        end

        // Write then read back, plus fault cases
        doTransaction(0, 1'b1, 32'h10, 32'hDEADBEEF, "wr10");
        doTransaction(0, 1'b0, 32'h10, 32'h0, "rd10");
        doTransaction(0, 1'b1, 32'h12, 32'h0BADF00D, "wr12_misaligned");
        doTransaction(0, 1'b0, 32'h10, 32'h0, "rd10_after_fault");
        doTransaction(0, 1'b0, 32'h400, 32'h0, "rd400_range");
        doTransaction(0, 1'b1, 32'h20, 32'hCAFEF00D, "wr20");
        doTransaction(0, 1'b1, 32'h40, 32'h40404040, "wr40");

        // Reset in the middle of a write's wait states drops the write
        @(negedge clk);
        driveReq(0, 1'b1, 1'b1, 32'h20, 32'h12345678);
        @(posedge clk);
        @(negedge clk);
        driveReq(0, 1'b0, 1'b0, '0, '0);
        checkOutput("midreset_busy", 32'(bus2.busy), 32'd1);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        n_ready = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus2.ready) n_ready++;
        end
        checkOutput("midreset_no_ready", 32'(n_ready), 32'd0);
        doTransaction(0, 1'b0, 32'h20, 32'h0, "rd20_after_reset");

        // Stray request during wait states is ignored
        @(negedge clk);
        driveReq(0, 1'b1, 1'b0, 32'h10, 32'h0);
        @(posedge clk);
        n_ready = 0;
        pulse_at = 0;
        pulse_rd = '0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) driveReq(0, 1'b1, 1'b1, 32'h40, 32'h55555555);
            else driveReq(0, 1'b0, 1'b0, '0, '0);
            if (bus2.ready) begin
                n_ready++;
                if (pulse_at == 0) begin
                    pulse_at = i;
                    pulse_rd = bus2.rd;
                end
            end
        end
        checkOutput("stray_pulses", 32'(n_ready), 32'd1);
        checkOutput("stray_latency", 32'(pulse_at), 32'd3);
        checkOutput("stray_rd", pulse_rd, model_mem[0][4]);
        doTransaction(0, 1'b0, 32'h40, 32'h0, "rd40_untouched");

        // Zero-wait instance: single request, then req held high
        doTransaction(1, 1'b1, 32'h10, 32'hA5A50F0F, "z_wr10");
        doTransaction(1, 1'b0, 32'h10, 32'h0, "z_rd10");
        @(negedge clk);
        driveReq(1, 1'b1, 1'b0, 32'h10, 32'h0);
        @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput($sformatf("held_ready_%0d", i), 32'(bus0.ready),
                        32'((i % (waitOf(1) + 2)) == waitOf(1)));
            if (bus0.ready) checkOutput($sformatf("held_rd_%0d", i), bus0.rd, model_mem[1][4]);
            if (i == 9) driveReq(1, 1'b0, 1'b0, '0, '0);
        end
        @(negedge clk);

        // Randomized traffic on both instances
        for (int n = 0; n < 40; n++) begin
            sel  = int'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 3));
            idx  = int'($urandom_range(0, 255));
            we   = 1'($urandom_range(0, 1));
            case (kind)
                0: begin
                    addr = 32'(idx * 4);
                    we = 1'b1;
                end
                1: begin
                    for (int t = 0; t < 64 && !model_valid[sel][idx]; t++) idx = (idx + 37) % 256;
                    if (!model_valid[sel][idx]) idx = 4;
                    addr = 32'(idx * 4);
                    we = 1'b0;
                end
                2: addr = 32'(idx * 4 + int'($urandom_range(1, 3)));
                default: addr = $urandom_range(32'h400, 32'hFFFF_FFFF);
            endcase
            doTransaction(sel, we, addr, $urandom, $sformatf("rand%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
